// File: rtl/port_ingress_queue.sv
`default_nettype none
// ============================================================================
// Module   : port_ingress_queue
// Purpose  : Host-side filter + FIFO + gap-paced issue into one switch port.
// Revision : 1.0
// ============================================================================
module port_ingress_queue #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic [3:0]                 host_source,
  input  logic [3:0]                 host_target,
  input  logic [7:0]                 host_data,
  input  logic                       sw_ready,
  output logic                       sw_valid,
  output logic [3:0]                 sw_source,
  output logic [3:0]                 sw_target,
  output logic [7:0]                 sw_data,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       drop_pulse,
  output logic [7:0]                 drop_cnt
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_FW   = $clog2(DEPTH + 1);
  localparam logic [3:0]      c_SRC  = 4'(1 << PORT_ID);
  localparam logic [c_FW-1:0] c_FULL = c_FW'(DEPTH);
  localparam logic [2:0]      c_GAP  = 3'(MIN_GAP);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GAP = 1'b1} state_t;

  logic [15:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_FW-1:0] r_fill;
  state_t          r_state;
  logic [2:0]      r_gap_cnt;
  logic            r_sw_valid;
  logic [15:0]     r_sw_pkt;
  logic            r_drop_pulse;
  logic [7:0]      r_drop_cnt;

  logic w_handshake;
  logic w_legal;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // No pop-to-push bypass: a full queue refuses even while it is draining.
  assign host_ready  = !rst && (r_fill != c_FULL);
  assign w_handshake = host_valid && host_ready;
  assign w_legal     = (host_source == c_SRC) && (host_target != 4'b0000) &&
                       !host_target[PORT_ID];
  assign w_push      = w_handshake && w_legal;
  assign w_drop      = w_handshake && !w_legal;
  assign w_pop       = (r_state == S_IDLE) && (r_fill != '0) && sw_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {host_source, host_target, host_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_sw_valid   <= 1'b0;
      r_sw_pkt     <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_sw_valid   <= w_pop;
      r_sw_pkt     <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + c_FW'(1);
        2'b01:   r_fill <= r_fill - c_FW'(1);
        default: r_fill <= r_fill;
      endcase
      case (r_state)
        S_IDLE: begin
          if (w_pop && (c_GAP != 3'd0)) begin
            r_state   <= S_GAP;
            r_gap_cnt <= c_GAP;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - 3'd1;
          if (r_gap_cnt <= 3'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sw_valid   = r_sw_valid;
  assign sw_source  = r_sw_pkt[15:12];
  assign sw_target  = r_sw_pkt[11:8];
  assign sw_data    = r_sw_pkt[7:0];
  assign fill       = r_fill;
  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_port_ingress_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_ingress_queue
// Purpose  : Scoreboard bench for two queue instances (port 0 and port 1).
// Revision : 1.0
// ============================================================================
module tb_port_ingress_queue;

  logic clk;
  logic rst;
  logic hv_a, hv_b, sr_a, sr_b;
  logic [3:0] hs, ht;
  logic [7:0] hd;

  logic       hr_a, sv_a, dp_a;
  logic [3:0] ss_a, st_a;
  logic [7:0] sd_a, dc_a;
  logic [2:0] fill_a;
  logic       hr_b, sv_b, dp_b;
  logic [3:0] ss_b, st_b;
  logic [7:0] sd_b, dc_b;
  logic [2:0] fill_b;

  typedef struct {
    logic [3:0] s;
    logic [3:0] t;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   ndrop_a = 0;
  int   ndrop_b = 0;

  port_ingress_queue #(.PORT_ID(0), .DEPTH(4), .MIN_GAP(1)) dut_a (
    .clk(clk), .rst(rst), .host_valid(hv_a), .host_ready(hr_a),
    .host_source(hs), .host_target(ht), .host_data(hd), .sw_ready(sr_a),
    .sw_valid(sv_a), .sw_source(ss_a), .sw_target(st_a), .sw_data(sd_a),
    .fill(fill_a), .drop_pulse(dp_a), .drop_cnt(dc_a)
  );

  port_ingress_queue #(.PORT_ID(1), .DEPTH(4), .MIN_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .host_valid(hv_b), .host_ready(hr_b),
    .host_source(hs), .host_target(ht), .host_data(hd), .sw_ready(sr_b),
    .sw_valid(sv_b), .sw_source(ss_b), .sw_target(st_b), .sw_data(sd_b),
    .fill(fill_b), .drop_pulse(dp_b), .drop_cnt(dc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon(input int sel, input logic v, input logic [3:0] s, input logic [3:0] t,
                     input logic [7:0] d);
    exp_t e;
    string p;
    p = (sel == 0) ? "a" : "b";
    if (v) begin
      if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
        chk({"unexpected_valid_", p}, v, 0);
      end else begin
        e = (sel == 0) ? qa.pop_front() : qb.pop_front();
        chk({"sw_source_", p}, s, e.s);
        chk({"sw_target_", p}, t, e.t);
        chk({"sw_data_", p}, d, e.d);
        if (e.cyc >= 0) chk({"issue_cycle_", p}, cyc, e.cyc);
      end
    end else begin
      chk({"idle_outputs_zero_", p}, {s, t, d}, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_a) ndrop_a++;
      if (dp_b) ndrop_b++;
      mon(0, sv_a, ss_a, st_a, sd_a);
      mon(1, sv_b, ss_b, st_b, sd_b);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input int sel, input logic [3:0] s, input logic [3:0] t,
                      input logic [7:0] d, input bit legal, input bit lat);
    bit   r;
    bit   done;
    exp_t e;
    done = 0;
    hs = s; ht = t; hd = d;
    if (sel == 0) hv_a = 1'b1; else hv_b = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      r = (sel == 0) ? hr_a : hr_b;
      @(posedge clk);
      #1;
      done = r;
    end
    hv_a = 1'b0;
    hv_b = 1'b0;
    chk("push_accepted", {31'd0, done}, 1);
    if (done && legal) begin
      e.s = s; e.t = t; e.d = d;
      e.cyc = lat ? cyc + 1 : -1;
      if (sel == 0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   ep;
    exp_t e;
    hv_a = 0; hv_b = 0; hs = 0; ht = 0; hd = 0; sr_a = 0; sr_b = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_host_ready_a", hr_a, 0);
    chk("rst_host_ready_b", hr_b, 0);
    chk("rst_sw_a", {sv_a, ss_a, st_a, sd_a}, 0);
    chk("rst_fill_a", fill_a, 0);
    chk("rst_drop_a", {dp_a, dc_a}, 0);
    chk("rst_drop_b", {dp_b, dc_b}, 0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("host_ready_after_rst", hr_a, 1);
    step(1);

    // Queued packets must vanish on a mid-operation reset.
    push(0, 4'b0001, 4'b0010, 8'h10, 0, 0);
    push(0, 4'b0001, 4'b0010, 8'h11, 0, 0);
    push(0, 4'b0001, 4'b0010, 8'h12, 0, 0);
    chk("fill_before_flush", fill_a, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("host_ready_in_rst", hr_a, 0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("fill_after_flush", fill_a, 0);
    chk("drop_cnt_after_flush", dc_a, 0);
    step(1);
    sr_a = 1'b1;
    step(6);

    push(0, 4'b0001, 4'b0100, 8'hA0, 1, 1);
    step(5);

    sr_b = 1'b1;
    push(1, 4'b0010, 4'b0000, 8'h31, 0, 0);
    push(1, 4'b0010, 4'b0010, 8'h32, 0, 0);
    push(1, 4'b0001, 4'b0100, 8'h33, 0, 0);
    push(1, 4'b0010, 4'b1100, 8'hB0, 1, 0);
    step(4);
    chk("filter_drop_cnt", dc_b, 3);
    chk("filter_drop_pulses", ndrop_b, 3);
    chk("port0_no_drops", dc_a, 0);

    sr_a = 1'b0;
    push(0, 4'b0001, 4'b0010, 8'hD0, 1, 0);
    push(0, 4'b0001, 4'b0010, 8'hD1, 1, 0);
    push(0, 4'b0001, 4'b0010, 8'hD2, 1, 0);
    push(0, 4'b0001, 4'b0010, 8'hD3, 1, 0);
    fork
      push(0, 4'b0001, 4'b0010, 8'hD4, 1, 0);
      begin
        step(3);
        chk("full_fill", fill_a, 4);
        chk("full_host_ready", hr_a, 0);
        sr_a = 1'b1;
      end
    join
    step(15);
    chk("drained_fill", fill_a, 0);

    sr_b = 1'b0;
    step(5);
    push(1, 4'b0010, 4'b0001, 8'hC0, 0, 0);
    push(1, 4'b0010, 4'b0001, 8'hC1, 0, 0);
    push(1, 4'b0010, 4'b0001, 8'hC2, 0, 0);
    chk("gap_fill", fill_b, 3);
    sr_b = 1'b1;
    ep = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.s = 4'b0010; e.t = 4'b0001; e.d = 8'hC0 + 8'(i); e.cyc = ep + 3 * i;
      qb.push_back(e);
    end
    step(12);

    for (int i = 0; i < 260; i++) begin
      push(1, 4'b0001, 4'b0100, 8'(i), 0, 0);
      if (i == 250) chk("drop_cnt_254", dc_b, 254);
      if (i == 251) chk("drop_cnt_255", dc_b, 255);
    end
    step(3);
    chk("drop_cnt_saturated", dc_b, 255);
    chk("drop_pulse_total", ndrop_b, 263);
    chk("port0_drop_pulses", ndrop_a, 0);

    step(10);
    chk("scoreboard_a_empty", qa.size(), 0);
    chk("scoreboard_b_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/port_ingress_queue.md
Name: port_ingress_queue

Overview:
- Per-port ingress stage that sits directly upstream of one switch_4port port. One instance per port.
- Accepts packets from a host over a valid/ready handshake and filters out malformed packets.
- Buffers legal packets in a DEPTH-entry FIFO.
- Issues them to the switch port as single-cycle valid pulses, gated by a switch-side ready and a programmable inter-packet gap.

Parameters:
- PORT_ID, 0, index (0..3) of the switch port this queue feeds; defines the legal one-hot source.
- DEPTH, 4, FIFO entries (power of two, >=2).
- MIN_GAP, 1, idle cycles forced between consecutive sw_valid pulses (0..7).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- host_valid  in  1  host packet present.
- host_ready  out  1  queue can accept; handshake on host_valid && host_ready.
- host_source  in  4  one-hot source.
- host_target  in  4  target bitmap (multicast/broadcast allowed).
- host_data  in  8  payload.
- sw_ready  in  1  switch port can take a new packet this cycle.
- sw_valid  out  1  to switch valid_in; one-cycle pulse per packet.
- sw_source  out  4  to switch source_in.
- sw_target  out  4  to switch target_in.
- sw_data  out  8  to switch data_in.
- fill  out  $clog2(DEPTH+1)  current FIFO occupancy.
- drop_pulse  out  1  one-cycle pulse per rejected packet.
- drop_cnt  out  8  saturating count of rejected packets.

Behaviour:
- Reset:
  - clk and synchronous active-high rst as already decided.
  - While rst=1 at an edge: FIFO flushed (pointers and fill=0), issue FSM to IDLE, gap counter 0.
  - All outputs are 0 during and after reset: sw_valid, sw_source, sw_target, sw_data, drop_pulse, drop_cnt.
  - host_ready=0 while rst=1.
  - Reset mid-operation discards all queued packets and any pending gap. No partial issue occurs.
- Ingress:
  - host_ready = !rst && (fill != DEPTH), computed combinationally from the current fill.
  - There is no same-cycle pop-to-push bypass: when full, host_ready=0 even if a pop occurs in that cycle.
- Validation, evaluated on handshake. A packet is legal iff all three hold:
  - host_source == (1<<PORT_ID)
  - host_target != 0
  - host_target[PORT_ID] == 0
- Rejected packets:
  - The handshake still completes, but nothing is written.
  - drop_pulse=1 for the following cycle.
  - drop_cnt increments and saturates at 255.
- Legal packets are written at the handshake edge, then fill increments.
- Issue FSM (states IDLE, GAP):
  - In IDLE with fill>0 and sw_ready=1 at an edge: pop the head and register it onto sw_source/sw_target/sw_data with sw_valid=1 for exactly one cycle. Then go to GAP with gap counter = MIN_GAP.
  - With MIN_GAP=0, stay in IDLE; back-to-back pulses are allowed.
  - In GAP: decrement the counter each cycle; return to IDLE when it reaches 0. No issue occurs in GAP regardless of sw_ready.
  - When sw_valid=0, sw_source, sw_target and sw_data are driven to 0.
  - sw_ready is sampled only in IDLE. Deassertion after a pulse has no effect on that pulse.
- Latency: a legal packet accepted at edge E0 into an empty queue, with sw_ready=1 and the FSM in IDLE, appears with sw_valid=1 after edge E1. Minimum latency is 1 cycle.
- Simultaneous push and pop in one edge: fill is unchanged, and FIFO ordering is strictly preserved.
- Pointers wrap modulo DEPTH. fill is never above DEPTH and never below 0.
- An empty queue never asserts sw_valid.

Test Plan:
- Reset flush: PORT_ID=0; push 3 legal packets with sw_ready=0, then pulse rst for 1 cycle -> fill=0, sw_valid stays 0 after sw_ready=1, drop_cnt=0.
- Unicast latency: PORT_ID=0, sw_ready=1; push src=0001, tgt=0100, data=A0 at edge E0 -> sw_valid=1 with 0001/0100/A0 after E1 only; outputs are zero otherwise.
- Filtering, PORT_ID=1: tgt=0000 dropped; tgt=0010 dropped; src=0001 dropped; src=0010, tgt=1100 accepted -> drop_cnt=3, three drop_pulses, one sw_valid with data B0.
- Full/backpressure: DEPTH=4, sw_ready=0; push 5 packets D0..D4 back-to-back -> host_ready=0 after the 4th, fill=4, D4 held by the host. Then sw_ready=1 -> D0..D4 emitted in order, and D4 is accepted once fill<4.
- Gap enforcement: MIN_GAP=2, 3 queued packets, sw_ready=1 continuously -> sw_valid pulses exactly 3 cycles apart (1 high, 2 low).
- Drop counter saturation: push 260 illegal packets -> drop_cnt=255, and a drop_pulse for each.
